tdm_demux: RTL and testbench
============================

# tdm_demux

Receive-side time-division demultiplexer: takes a serial bit stream with a frame-sync marker and distributes it into N_CH parallel W-bit channel words. It is the far end of the channel-select multiplexing path: the transmit side interleaves channels onto one wire, and this block separates them again. It sits between the serial link input and the per-channel consumers, with registered outputs and sync-error reporting.

## Interface
- N_CH, 4, number of channels per frame (≥2)
- W, 8, bits per channel word (≥2)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- D  in  1  serial data bit, MSB of each channel first
- EN  in  1  bit-valid; D and FS are sampled only when EN=1
- FS  in  1  frame sync; high with the first bit (ch0 MSB) of a frame
- Y  out  N_CH*W  channel words; ch k occupies Y[k*W +: W]
- CH_STB  out  N_CH  one-hot, 1-cycle pulse when channel k's word in Y updates
- VALID  out  1  1-cycle pulse when the last channel of a frame completes
- SYNC_ERR  out  1  1-cycle pulse on a framing violation

## Operation
- States: IDLE (hunting for FS), RUN (inside a frame).
- Counters: bit_cnt (0..W-1, width $clog2(W)) and ch_cnt (0..N_CH-1, width $clog2(N_CH)); shift register sr[W-1:0]. Bits shift in MSB-first: sr <= {sr[W-2:0], D}.
- IDLE: an EN=1 cycle with FS=0 is discarded. An EN=1 cycle with FS=1 loads D as bit 0 of ch0, sets bit_cnt=1 and ch_cnt=0, and moves to RUN.
- RUN, EN=1, FS=0, mid-frame: shift D in. When bit_cnt=W-1, write {sr[W-2:0],D} into slice ch_cnt of Y, pulse CH_STB[ch_cnt], clear bit_cnt, and advance ch_cnt. On ch_cnt=N_CH-1, also pulse VALID and wrap ch_cnt to 0. The state stays RUN, expecting a new frame.
- RUN, expected frame start (bit_cnt=0, ch_cnt=0): FS=1 starts the next frame normally. FS=0 discards the bit, pulses SYNC_ERR, and goes to IDLE.
- RUN, FS=1 anywhere other than the expected frame start: pulse SYNC_ERR, drop the partial channel word, and treat D as bit 0 of ch0 (bit_cnt=1, ch_cnt=0). The state stays RUN. Y slices already completed in the aborted frame keep their values.
- EN=0: nothing changes; counters, sr and Y hold, and FS is ignored.
- Y slices change only on channel completion. Slices that are not being written hold their value.

## Timing
- Reset values: Y=0, CH_STB=0, VALID=0, SYNC_ERR=0, state=IDLE, counters=0, sr=0. Asserting rst mid-frame discards the frame immediately (asynchronous).
- Latency: the last bit of a channel is sampled at edge k. After that edge, Y, CH_STB and (for the last channel) VALID are visible in the same cycle, i.e. registered outputs with 1-cycle latency from the bit.
- Pulses last exactly one clk cycle, even if EN is high back-to-back.
- Back-to-back frames at EN=1 every cycle give one VALID every N_CH*W cycles.
- SYNC_ERR and CH_STB are never high in the same cycle. A resync FS cancels any completion for that cycle.
- Throughput: 1 bit per EN=1 cycle, with no backpressure.

## Structure
- Package tdm_pkg: the state enum (IDLE, RUN). The channel-slice width helper is a package localparam.
- Sub-module serial_shift_in: the W-bit shift register plus bit counter. It has a load_first input (start a new word with D) and a word_done output. tdm_demux holds the FSM, ch_cnt, the Y registers and the strobes.

## Test plan
Parameters N_CH=4, W=8, EN=1 unless stated.
- Clean frame: A5,3C,0F,F0, FS on the first bit.
  - CH_STB pulses 0001, 0010, 0100, 1000 at cycles 8, 16, 24, 32.
  - VALID pulses at cycle 32 with Y=32'hF00F3CA5.
  - SYNC_ERR stays 0.
- Two back-to-back frames, the second being 11,22,33,44, each with FS:
  - VALID pulses exactly 32 cycles apart.
  - The final value is Y=32'h44332211.
- EN gaps: the same clean frame with EN=0 on every third cycle.
  - The result is identical Y and strobe order, with timing stretched.
- Early FS: FS at bit 5 of ch1.
  - SYNC_ERR pulses.
  - A full new frame 01,02,03,04 follows and gives VALID with Y=32'h04030201.
- Missing FS:
  - After a valid frame, the next bit arrives without FS, giving a SYNC_ERR pulse and a return to IDLE.
  - Further bits without FS are ignored, with no strobes.
- Reset mid-frame: assert rst during ch2 of a frame.
  - All outputs go to 0 and the state goes to IDLE.
  - After release, a fresh FS frame decodes correctly.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM receive demultiplexer.
//   IDLE : hunting for a frame-sync marker
//   RUN  : inside a frame, collecting channel words
package tdm_pkg;

    localparam int unsigned DEF_N_CH = 4;  // channels per frame
    localparam int unsigned DEF_W    = 8;  // bits per channel slice

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_demux_serial_shift_in.sv
// MSB-first serial-to-parallel shifter with bit counter.
// Ports:
//   clk, rst     : clock, async active-high reset
//   d            : serial data bit
//   shift        : append d to the current word
//   load_first   : start a new word with d as its first bit (wins over shift)
//   word_c       : word that would complete if d is accepted now
//   word_done_c  : the next accepted bit is the last bit of the word
//   word_start_c : no bits of the current word collected yet
module serial_shift_in
    import tdm_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         d,
    input  logic         shift,
    input  logic         load_first,
    output logic [W-1:0] word_c,
    output logic         word_done_c,
    output logic         word_start_c
);

    localparam int unsigned BW  = (W > 1) ? $clog2(W) : 1;
    // Only the W-1 most recent bits are stored; the live d completes a word.
    localparam int unsigned SRW = W - 1;

    logic [SRW-1:0] sr_q;
    logic [BW-1:0]  bit_cnt_q;

    assign word_c       = {sr_q, d};
    assign word_done_c  = (bit_cnt_q == BW'(W - 1));
    assign word_start_c = (bit_cnt_q == '0);

    // Shift register and bit position within the current word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else if (load_first) begin
            sr_q      <= SRW'(d);
            bit_cnt_q <= BW'(1);
        end else if (shift) begin
            sr_q      <= SRW'({sr_q, d});
            bit_cnt_q <= word_done_c ? '0 : bit_cnt_q + BW'(1);
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Receive-side TDM demultiplexer: splits a framed serial stream into
// N_CH parallel W-bit channel words.
// Ports:
//   clk, rst  : clock, async active-high reset
//   D         : serial data, MSB of each channel first
//   EN        : bit-valid; D and FS are ignored when low
//   FS        : frame sync, high with ch0 MSB
//   Y         : channel words, ch k at Y[k*W +: W] (registered)
//   CH_STB    : one-hot pulse when a channel slice of Y updates
//   VALID     : pulse when the last channel of a frame completes
//   SYNC_ERR  : pulse on a framing violation
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int unsigned N_CH = DEF_N_CH,
    parameter int unsigned W    = DEF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              D,
    input  logic              EN,
    input  logic              FS,
    output logic [N_CH*W-1:0] Y,
    output logic [N_CH-1:0]   CH_STB,
    output logic              VALID,
    output logic              SYNC_ERR
);

    localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_t             state_q, state_d;
    logic [CW-1:0]      ch_cnt_q, ch_cnt_d;
    logic [N_CH*W-1:0]  y_q, y_d;
    logic [N_CH-1:0]    ch_stb_q, ch_stb_d;
    logic               valid_q, valid_d;
    logic               sync_err_q, sync_err_d;

    logic               shift, load_first;
    logic [W-1:0]       word_c;
    logic               word_done_c, word_start_c;
    logic               frame_start;

    serial_shift_in #(.W(W)) u_shift (
        .clk          (clk),
        .rst          (rst),
        .d            (D),
        .shift        (shift),
        .load_first   (load_first),
        .word_c       (word_c),
        .word_done_c  (word_done_c),
        .word_start_c (word_start_c)
    );

    assign frame_start = word_start_c && (ch_cnt_q == '0);

    // Next-state, channel counter, Y slice update and strobes
    always_comb begin
        state_d    = state_q;
        ch_cnt_d   = ch_cnt_q;
        y_d        = y_q;
        ch_stb_d   = '0;
        valid_d    = 1'b0;
        sync_err_d = 1'b0;
        shift      = 1'b0;
        load_first = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (EN && FS) begin
                    load_first = 1'b1;
                    ch_cnt_d   = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (EN) begin
                    if (FS) begin
                        // FS always restarts at ch0; off-boundary it is a resync
                        load_first = 1'b1;
                        ch_cnt_d   = '0;
                        sync_err_d = !frame_start;
                    end else if (frame_start) begin
                        sync_err_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        shift = 1'b1;
                        if (word_done_c) begin
                            for (int k = 0; k < int'(N_CH); k++) begin
                                if (ch_cnt_q == CW'(k)) begin
                                    y_d[k*W +: W] = word_c;
                                    ch_stb_d[k]   = 1'b1;
                                end
                            end
                            if (ch_cnt_q == CW'(N_CH - 1)) begin
                                valid_d  = 1'b1;
                                ch_cnt_d = '0;
                            end else begin
                                ch_cnt_d = ch_cnt_q + CW'(1);
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ch_cnt_q   <= '0;
            y_q        <= '0;
            ch_stb_q   <= '0;
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_cnt_q   <= ch_cnt_d;
            y_q        <= y_d;
            ch_stb_q   <= ch_stb_d;
            valid_q    <= valid_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign Y        = y_q;
    assign CH_STB   = ch_stb_q;
    assign VALID    = valid_q;
    assign SYNC_ERR = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (N_CH=4, W=8): clean, back-to-back, EN-gapped,
// early-FS, missing-FS and mid-frame-reset frames with hand-computed results.
module tb_tdm_demux;

    localparam int N_CH = 4;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              D, EN, FS;
    logic [N_CH*W-1:0] Y;
    logic [N_CH-1:0]   CH_STB;
    logic              VALID, SYNC_ERR;

    int n_tests = 0;
    int n_fail  = 0;
    int gcyc    = 0;
    int base    = 0;
    int gap     = 0;
    int gap_c   = 0;
    int viol    = 0;
    int stb_q[$];
    int stb_cyc_q[$];
    int valid_cyc_q[$];
    int sync_cyc_q[$];

    tdm_demux #(.N_CH(N_CH), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .D        (D),
        .EN       (EN),
        .FS       (FS),
        .Y        (Y),
        .CH_STB   (CH_STB),
        .VALID    (VALID),
        .SYNC_ERR (SYNC_ERR)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, sample outputs 1 time unit after the edge
    task automatic step(input logic d, input logic fs, input logic en);
        D  = d;
        FS = fs;
        EN = en;
        @(posedge clk);
        #1;
        gcyc++;
        if (CH_STB != '0) begin
            stb_q.push_back(int'(CH_STB));
            stb_cyc_q.push_back(gcyc - base);
        end
        if (VALID)    valid_cyc_q.push_back(gcyc - base);
        if (SYNC_ERR) sync_cyc_q.push_back(gcyc - base);
        if ((CH_STB != '0 && SYNC_ERR) || (VALID && !CH_STB[N_CH-1]) ||
            ($countones(CH_STB) > 1))
            viol++;
    endtask

    // Send one valid bit; when gapping, every gap-th cycle is EN=0 with noisy D/FS
    task automatic send_bit(input logic d, input logic fs);
        if (gap != 0 && (gap_c % gap) == gap - 1) begin
            step(~d, 1'b1, 1'b0);
            gap_c++;
        end
        step(d, fs, 1'b1);
        gap_c++;
    endtask

    task automatic send_byte(input logic [7:0] v, input int nbits, input logic fs_first);
        for (int i = 0; i < nbits; i++)
            send_bit(v[7-i], fs_first && (i == 0));
    endtask

    task automatic send_frame(input logic [31:0] w);
        for (int c = 0; c < N_CH; c++)
            send_byte(w[c*W +: W], W, c == 0);
    endtask

    task automatic clear_log();
        stb_q.delete();
        stb_cyc_q.delete();
        valid_cyc_q.delete();
        sync_cyc_q.delete();
        base  = gcyc;
        gap_c = 0;
    endtask

    // Expect one full frame: strobes 1,2,4,8 at given cycles, VALID with the last
    task automatic check_frame(input string tag, input int first, input int c0, input int c1,
                               input int c2, input int c3);
        int ec[4];
        ec = '{c0, c1, c2, c3};
        for (int i = 0; i < N_CH; i++) begin
            check($sformatf("%s_stb%0d", tag, i), 32'(stb_q[first+i]), 32'(1 << i));
            check($sformatf("%s_cyc%0d", tag, i), 32'(stb_cyc_q[first+i]), 32'(ec[i]));
        end
    endtask

    initial begin
        rst = 1'b1;
        D   = 1'b0;
        EN  = 1'b0;
        FS  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_y",        Y,               32'h0);
        check("rst_ch_stb",   32'(CH_STB),     32'h0);
        check("rst_valid",    32'(VALID),      32'h0);
        check("rst_sync_err", 32'(SYNC_ERR),   32'h0);
        rst = 1'b0;

        // Clean frame
        clear_log();
        send_frame(32'hF00F3CA5);
        check("clean_nstb", 32'(stb_q.size()), 32'd4);
        check_frame("clean", 0, 8, 16, 24, 32);
        check("clean_nvalid", 32'(valid_cyc_q.size()), 32'd1);
        check("clean_valid_cyc", 32'(valid_cyc_q[0]), 32'd32);
        check("clean_y", Y, 32'hF00F3CA5);
        check("clean_nsync", 32'(sync_cyc_q.size()), 32'd0);

        // Two back-to-back frames
        clear_log();
        send_frame(32'hF00F3CA5);
        send_frame(32'h44332211);
        check("b2b_nvalid", 32'(valid_cyc_q.size()), 32'd2);
        check("b2b_valid_gap", 32'(valid_cyc_q[1] - valid_cyc_q[0]), 32'd32);
        check("b2b_y", Y, 32'h44332211);
        check("b2b_nsync", 32'(sync_cyc_q.size()), 32'd0);

        // EN=0 every third cycle: bit n lands on cycle n + (n-1)/2
        clear_log();
        gap = 3;
        send_frame(32'hF00F3CA5);
        gap = 0;
        check("gap_nstb", 32'(stb_q.size()), 32'd4);
        check_frame("gap", 0, 11, 23, 35, 47);
        check("gap_valid_cyc", 32'(valid_cyc_q[0]), 32'd47);
        check("gap_y", Y, 32'hF00F3CA5);
        check("gap_nsync", 32'(sync_cyc_q.size()), 32'd0);

        // Early FS on the 6th bit of ch1, which begins a new full frame
        clear_log();
        send_byte(8'h77, 8, 1'b1);
        send_byte(8'h00, 5, 1'b0);
        check("early_partial_y", Y, 32'hF00F3C77);
        send_frame(32'h04030201);
        check("early_nsync", 32'(sync_cyc_q.size()), 32'd1);
        check("early_sync_cyc", 32'(sync_cyc_q[0]), 32'd14);
        check("early_nstb", 32'(stb_q.size()), 32'd5);
        check("early_stb_aborted", 32'(stb_q[0]), 32'd1);
        check_frame("early", 1, 21, 29, 37, 45);
        check("early_nvalid", 32'(valid_cyc_q.size()), 32'd1);
        check("early_valid_cyc", 32'(valid_cyc_q[0]), 32'd45);
        check("early_y", Y, 32'h04030201);

        // Missing FS at the expected frame start, then bits without FS are ignored
        clear_log();
        send_byte(8'hC3, 8, 1'b0);
        send_byte(8'hAA, 8, 1'b0);
        send_byte(8'h55, 8, 1'b0);
        check("miss_nsync", 32'(sync_cyc_q.size()), 32'd1);
        check("miss_sync_cyc", 32'(sync_cyc_q[0]), 32'd1);
        check("miss_nstb", 32'(stb_q.size()), 32'd0);
        check("miss_nvalid", 32'(valid_cyc_q.size()), 32'd0);
        check("miss_y", Y, 32'h04030201);

        // Reset during ch2
        clear_log();
        send_byte(8'hA5, 8, 1'b1);
        send_byte(8'h3C, 8, 1'b0);
        send_byte(8'h0F, 3, 1'b0);
        check("rstmid_nstb", 32'(stb_q.size()), 32'd2);
        check("rstmid_pre_y", Y, 32'h04033CA5);
        rst = 1'b1;
        #2;
        check("rstmid_y",        Y,             32'h0);
        check("rstmid_ch_stb",   32'(CH_STB),   32'h0);
        check("rstmid_valid",    32'(VALID),    32'h0);
        check("rstmid_sync_err", 32'(SYNC_ERR), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
        send_frame(32'hDEADBEEF);
        check("after_rst_nstb", 32'(stb_q.size()), 32'd4);
        check_frame("after_rst", 0, 8, 16, 24, 32);
        check("after_rst_valid_cyc", 32'(valid_cyc_q[0]), 32'd32);
        check("after_rst_nsync", 32'(sync_cyc_q.size()), 32'd0);
        check("after_rst_y", Y, 32'hDEADBEEF);

        check("strobe_exclusivity", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
